// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: moves one sample at a time through rbuf and the HLS FIR core,
// captures the filter result and presents it on a valid/ready output.
// It also muxes the x_ant and coefficient BRAM addresses between rbuf and the filter.
//
// state     | meaning
// IDLE      | ready for a sample (s_ready=1)
// LOAD      | rbuf_en held for 2 cycles with the latched sample
// WAIT_RBUF | waiting for rbuf_done, watchdog running
// START     | filt_start held for START_CYCLES cycles
// RUN       | waiting for filt_done, watchdog running
// OUT       | result presented until m_ready

module fir_seq_ctrl #(
    parameter int M            = 23,
    parameter int ADDR_SIZE    = 5,
    parameter int DATA_SIZE    = 16,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_SIZE-1:0]   s_data,
    input  logic [1:0]             filt_sel,
    input  logic                   dc_en,
    output logic                   rbuf_en,
    output logic [DATA_SIZE-1:0]   rbuf_di,
    input  logic [ADDR_SIZE-1:0]   rbuf_addr,
    input  logic                   rbuf_owe,
    input  logic                   rbuf_done,
    output logic                   filt_start,
    input  logic                   filt_done,
    input  logic [DATA_SIZE-1:0]   filt_result,
    input  logic [ADDR_SIZE-1:0]   filt_xant_addr,
    input  logic [ADDR_SIZE-1:0]   filt_xcoefs_addr,
    output logic                   filt_dc_en,
    output logic [ADDR_SIZE-1:0]   xant_addr,
    output logic                   xant_we,
    output logic [ADDR_SIZE+1:0]   coefs_addr,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_SIZE-1:0]   m_data,
    output logic [15:0]            sample_cnt,
    output logic                   busy,
    output logic                   timeout_err
);

    // One down-counter serves the LOAD and START pulse widths and the watchdog.
    localparam int TW = (TIMEOUT > 8) ? $clog2(TIMEOUT) : 3;

    localparam logic [ADDR_SIZE-1:0] ADDR_MAX  = ADDR_SIZE'(M - 1);
    localparam logic [TW-1:0]        LOAD_LEN  = TW'(1);
    localparam logic [TW-1:0]        START_LEN = TW'(START_CYCLES - 1);
    localparam logic [TW-1:0]        WDOG_LEN  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_RBUF,
        START,
        RUN,
        OUT
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [TW-1:0]        tmr;
    logic [TW-1:0]        tmr_val;
    logic                 tmr_ld;
    logic                 tmr_tc;
    logic                 accept;
    logic                 capture;
    logic                 handshake;
    logic                 wdog_hit;
    logic [DATA_SIZE-1:0] data_q;
    logic [1:0]           sel_q;
    logic                 dc_q;

    assign tmr_tc = (tmr == '0);

    // Next-state decode; the timer is reloaded on every state entry that needs it.
    always_comb begin
        state_nx  = state;
        tmr_ld    = 1'b0;
        tmr_val   = '0;
        accept    = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        wdog_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid) begin
                    accept   = 1'b1;
                    state_nx = LOAD;
                    tmr_ld   = 1'b1;
                    tmr_val  = LOAD_LEN;
                end
            end
            LOAD: begin
                if (tmr_tc) begin
                    state_nx = WAIT_RBUF;
                    tmr_ld   = 1'b1;
                    tmr_val  = WDOG_LEN;
                end
            end
            WAIT_RBUF: begin
                if (rbuf_done) begin
                    state_nx = START;
                    tmr_ld   = 1'b1;
                    tmr_val  = START_LEN;
                end else if (tmr_tc) begin
                    wdog_hit = 1'b1;
                    state_nx = IDLE;
                end
            end
            START: begin
                if (tmr_tc) begin
                    state_nx = RUN;
                    tmr_ld   = 1'b1;
                    tmr_val  = WDOG_LEN;
                end
            end
            RUN: begin
                if (filt_done) begin
                    capture  = 1'b1;
                    state_nx = OUT;
                end else if (tmr_tc) begin
                    wdog_hit = 1'b1;
                    state_nx = IDLE;
                end
            end
            OUT: begin
                if (m_ready) begin
                    handshake = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Shared down-counter: load on state entry, count to zero and hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          tmr <= '0;
        else if (tmr_ld)  tmr <= tmr_val;
        else if (!tmr_tc) tmr <= tmr - 1'b1;
    end

    // Sample and per-run configuration are captured only on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            sel_q  <= '0;
            dc_q   <= 1'b0;
        end else if (accept) begin
            data_q <= s_data;
            sel_q  <= filt_sel;
            dc_q   <= dc_en;
        end
    end

    // Result capture, completed-sample count and sticky watchdog flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data      <= '0;
            sample_cnt  <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (capture)   m_data      <= filt_result;
            if (handshake) sample_cnt  <= sample_cnt + 16'd1;
            if (wdog_hit)  timeout_err <= 1'b1;
        end
    end

    // Strobes decode straight from state so rst drops them without waiting for a clock.
    assign s_ready    = (state == IDLE);
    assign busy       = (state != IDLE);
    assign rbuf_en    = (state == LOAD);
    assign filt_start = (state == START);
    assign m_valid    = (state == OUT);
    assign rbuf_di    = data_q;
    assign filt_dc_en = dc_q;

    // Out-of-range filter addresses fold to 0 so the filter never reads past the M-deep banks.
    assign xant_we    = rbuf_owe;
    assign xant_addr  = rbuf_owe ? rbuf_addr
                      : ((filt_xant_addr > ADDR_MAX) ? '0 : filt_xant_addr);
    assign coefs_addr = (filt_xcoefs_addr > ADDR_MAX) ? '0 : {sel_q, filt_xcoefs_addr};

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Testbench for fir_seq_ctrl: stub rbuf/filter driven from a cycle-timing model.
module tb_fir_seq_ctrl;
    localparam int M  = 23;
    localparam int AW = 5;
    localparam int DW = 16;
    localparam int SC = 2;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, dc_en;
    logic [DW-1:0] s_data;
    logic [1:0]    filt_sel;
    logic          rbuf_en, rbuf_owe, rbuf_done;
    logic [DW-1:0] rbuf_di;
    logic [AW-1:0] rbuf_addr;
    logic          filt_start, filt_done, filt_dc_en;
    logic [DW-1:0] filt_result;
    logic [AW-1:0] filt_xant_addr, filt_xcoefs_addr, xant_addr;
    logic          xant_we;
    logic [AW+1:0] coefs_addr;
    logic          m_valid, m_ready, busy, timeout_err;
    logic [DW-1:0] m_data;
    logic [15:0]   sample_cnt;

    int checks   = 0;
    int failures = 0;

    logic [15:0]   exp_cnt   = '0;
    logic [1:0]    cur_sel   = '0;
    logic          cur_dc    = 1'b0;
    logic          exp_to    = 1'b0;
    logic [DW-1:0] exp_mdata = '0;

    always #5 clk = ~clk;

    fir_seq_ctrl #(.M(M), .ADDR_SIZE(AW), .DATA_SIZE(DW), .START_CYCLES(SC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .filt_sel(filt_sel), .dc_en(dc_en),
        .rbuf_en(rbuf_en), .rbuf_di(rbuf_di), .rbuf_addr(rbuf_addr), .rbuf_owe(rbuf_owe),
        .rbuf_done(rbuf_done),
        .filt_start(filt_start), .filt_done(filt_done), .filt_result(filt_result),
        .filt_xant_addr(filt_xant_addr), .filt_xcoefs_addr(filt_xcoefs_addr), .filt_dc_en(filt_dc_en),
        .xant_addr(xant_addr), .xant_we(xant_we), .coefs_addr(coefs_addr),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .sample_cnt(sample_cnt), .busy(busy), .timeout_err(timeout_err)
    );

    // Reference address map: bank select above the tap index, out-of-range taps go to 0.
    function automatic logic [AW-1:0] exp_xant(input logic owe, input logic [AW-1:0] ra,
                                               input logic [AW-1:0] fa);
        if (owe) return ra;
        if (int'(fa) > M - 1) return '0;
        return fa;
    endfunction

    function automatic logic [AW+1:0] exp_coefs(input logic [1:0] sel, input logic [AW-1:0] fc);
        if (int'(fc) > M - 1) return '0;
        return (AW+2)'(int'(sel) * (2 ** AW) + int'(fc));
    endfunction

    task automatic init_inputs();
        s_valid = 0; s_data = '0; filt_sel = '0; dc_en = 0;
        rbuf_addr = '0; rbuf_owe = 0; rbuf_done = 0;
        filt_done = 0; filt_result = '0; filt_xant_addr = '0; filt_xcoefs_addr = '0;
        m_ready = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        init_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_cnt = '0; exp_to = 1'b0; cur_sel = '0; cur_dc = 1'b0; exp_mdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        init_inputs();
        repeat (2) @(negedge clk);
        checks++; if (s_ready !== 1'b1)      begin failures++; $display("FAIL reset_s_ready got=%b req=1", s_ready); end
        checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL reset_busy got=%b req=0", busy); end
        checks++; if (rbuf_en !== 1'b0)      begin failures++; $display("FAIL reset_rbuf_en got=%b req=0", rbuf_en); end
        checks++; if (filt_start !== 1'b0)   begin failures++; $display("FAIL reset_filt_start got=%b req=0", filt_start); end
        checks++; if (m_valid !== 1'b0)      begin failures++; $display("FAIL reset_m_valid got=%b req=0", m_valid); end
        checks++; if (m_data !== '0)         begin failures++; $display("FAIL reset_m_data got=%h req=0", m_data); end
        checks++; if (sample_cnt !== '0)     begin failures++; $display("FAIL reset_sample_cnt got=%0d req=0", sample_cnt); end
        checks++; if (timeout_err !== 1'b0)  begin failures++; $display("FAIL reset_timeout_err got=%b req=0", timeout_err); end
        checks++; if (filt_dc_en !== 1'b0)   begin failures++; $display("FAIL reset_filt_dc_en got=%b req=0", filt_dc_en); end
        checks++; if (rbuf_di !== '0)        begin failures++; $display("FAIL reset_rbuf_di got=%h req=0", rbuf_di); end
        checks++; if (xant_we !== 1'b0)      begin failures++; $display("FAIL reset_xant_we got=%b req=0", xant_we); end
        checks++; if (xant_addr !== '0)      begin failures++; $display("FAIL reset_xant_addr got=%h req=0", xant_addr); end
        checks++; if (coefs_addr !== '0)     begin failures++; $display("FAIL reset_coefs_addr got=%h req=0", coefs_addr); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL post_reset_idle s_ready=%b busy=%b req 1/0", s_ready, busy);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 50; i++) begin
            rbuf_done   = 1'($urandom_range(0, 1));
            filt_done   = 1'($urandom_range(0, 1));
            filt_result = DW'($urandom);
            m_ready     = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++; if (rbuf_en !== 1'b0 || filt_start !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL idle_quiet i=%0d rbuf_en=%b filt_start=%b m_valid=%b busy=%b req 0000",
                         i, rbuf_en, filt_start, m_valid, busy);
            end
        end
        rbuf_done = 0; filt_done = 0; m_ready = 0;
    endtask

    // One sample through the stub: rbuf_done sampled at edge dd, filt_done at edge dd+SC+flat,
    // m_ready withheld for bp cycles of OUT. Sample point s is the negedge after edge s-1... s.
    task automatic do_sample(input logic [DW-1:0] d, input logic [1:0] sel, input logic dc,
                             input int dd, input int flat, input logic [DW-1:0] res,
                             input int bp, input bit noise);
        int   ff, last;
        logic e_en, e_st, e_mv, e_busy;
        ff   = dd + SC + flat;
        last = ff + 1 + bp;
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL accept_ready got=%b req=1", s_ready); end
        s_valid = 1'b1; s_data = d; filt_sel = sel; dc_en = dc;
        @(posedge clk);
        cur_sel = sel; cur_dc = dc;
        for (int s = 1; s <= last + 1; s++) begin
            @(negedge clk);
            e_en   = (s <= 2);
            e_st   = (s > dd) && (s <= dd + SC);
            e_mv   = (s > ff) && (s <= last);
            e_busy = (s <= last);
            if (s == last + 1) begin exp_cnt = exp_cnt + 16'd1; exp_mdata = res; end
            checks++; if (rbuf_en !== e_en)     begin failures++; $display("FAIL rbuf_en s=%0d got=%b req=%b", s, rbuf_en, e_en); end
            checks++; if (filt_start !== e_st)  begin failures++; $display("FAIL filt_start s=%0d got=%b req=%b", s, filt_start, e_st); end
            checks++; if (m_valid !== e_mv)     begin failures++; $display("FAIL m_valid s=%0d got=%b req=%b", s, m_valid, e_mv); end
            checks++; if (busy !== e_busy)      begin failures++; $display("FAIL busy s=%0d got=%b req=%b", s, busy, e_busy); end
            checks++; if (s_ready !== !e_busy)  begin failures++; $display("FAIL s_ready s=%0d got=%b req=%b", s, s_ready, !e_busy); end
            checks++; if (sample_cnt !== exp_cnt) begin failures++; $display("FAIL sample_cnt s=%0d got=%0d req=%0d", s, sample_cnt, exp_cnt); end
            checks++; if (timeout_err !== exp_to) begin failures++; $display("FAIL timeout_err s=%0d got=%b req=%b", s, timeout_err, exp_to); end
            checks++; if (filt_dc_en !== cur_dc)  begin failures++; $display("FAIL filt_dc_en s=%0d got=%b req=%b", s, filt_dc_en, cur_dc); end
            checks++; if (coefs_addr !== exp_coefs(cur_sel, filt_xcoefs_addr)) begin
                failures++; $display("FAIL coefs_run s=%0d got=%h req=%h", s, coefs_addr, exp_coefs(cur_sel, filt_xcoefs_addr));
            end
            if (e_en) begin
                checks++; if (rbuf_di !== d) begin failures++; $display("FAIL rbuf_di s=%0d got=%h req=%h", s, rbuf_di, d); end
            end
            if (e_mv) begin
                checks++; if (m_data !== res) begin failures++; $display("FAIL m_data s=%0d got=%h req=%h", s, m_data, res); end
            end
            s_valid     = (s <= last) ? 1'($urandom_range(0, 1)) : 1'b0;
            s_data      = DW'($urandom);
            filt_sel    = 2'($urandom_range(0, 2));
            dc_en       = 1'($urandom_range(0, 1));
            rbuf_done   = (s == dd) ||
                          (noise && (s <= 2 || (s > dd && s <= last)) && ($urandom_range(0, 3) == 0));
            filt_done   = (s == ff) ||
                          (noise && (s <= dd + SC || (s > ff && s <= last)) && ($urandom_range(0, 3) == 0));
            filt_result = (s == ff) ? res : DW'($urandom);
            m_ready     = (s == last) ? 1'b1 : ((s > ff) ? 1'b0 : 1'($urandom_range(0, 1)));
            filt_xcoefs_addr = AW'($urandom_range(0, 31));
        end
    endtask

    task automatic test_single();
        do_sample(16'h1234, 2'b10, 1'b1, 5, 40, 16'h0ABC, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_sample(16'hBEEF, 2'b10, 1'b0, 4, 12, 16'h4321, 10, 1'b0);
    endtask

    task automatic test_addr_mux();
        logic          t_owe [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [AW-1:0] t_ra  [5] = '{5'd7, 5'd7, 5'd0, 5'd31, 5'd31};
        logic [AW-1:0] t_fx  [5] = '{5'd25, 5'd25, 5'd22, 5'd23, 5'd3};
        logic [AW-1:0] t_fc  [5] = '{5'd3, 5'd31, 5'd22, 5'd23, 5'd0};
        logic [AW-1:0] t_xa  [5] = '{5'd7, 5'd0, 5'd22, 5'd0, 5'd31};
        logic [AW+1:0] t_ca  [5] = '{7'h43, 7'h00, 7'h56, 7'h00, 7'h40};
        // Bank select 10 was latched by the previous sample.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rbuf_owe = t_owe[i]; rbuf_addr = t_ra[i]; filt_xant_addr = t_fx[i]; filt_xcoefs_addr = t_fc[i];
            #1;
            checks++; if (xant_addr !== t_xa[i]) begin failures++; $display("FAIL mux_xant i=%0d got=%0d req=%0d", i, xant_addr, t_xa[i]); end
            checks++; if (xant_we !== t_owe[i])  begin failures++; $display("FAIL mux_we i=%0d got=%b req=%b", i, xant_we, t_owe[i]); end
            checks++; if (coefs_addr !== t_ca[i]) begin failures++; $display("FAIL mux_coefs i=%0d got=%h req=%h", i, coefs_addr, t_ca[i]); end
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rbuf_owe = 1'($urandom_range(0, 1));
            rbuf_addr = AW'($urandom_range(0, 31));
            filt_xant_addr = AW'($urandom_range(0, 31));
            filt_xcoefs_addr = AW'($urandom_range(0, 31));
            #1;
            checks++; if (xant_addr !== exp_xant(rbuf_owe, rbuf_addr, filt_xant_addr)) begin
                failures++; $display("FAIL mux_xant_rand i=%0d got=%0d req=%0d", i, xant_addr,
                                     exp_xant(rbuf_owe, rbuf_addr, filt_xant_addr));
            end
            checks++; if (coefs_addr !== exp_coefs(cur_sel, filt_xcoefs_addr)) begin
                failures++; $display("FAIL mux_coefs_rand i=%0d got=%h req=%h", i, coefs_addr,
                                     exp_coefs(cur_sel, filt_xcoefs_addr));
            end
        end
        rbuf_owe = 0; rbuf_addr = '0; filt_xant_addr = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            do_sample(DW'($urandom), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                      $urandom_range(3, 12), $urandom_range(3, 30), DW'($urandom),
                      $urandom_range(0, 4), 1'b1);
        end
    endtask

    // Done arriving on the very last watchdog cycle still counts.
    task automatic test_timeout_boundary();
        do_sample(16'h0F0F, 2'b01, 1'b0, 2 + TO, TO, 16'h7E57, 1, 1'b0);
    endtask

    task automatic do_timeout(input bit in_run);
        int   dd, end_s;
        logic e_busy, e_st;
        dd    = 4;
        end_s = in_run ? dd + SC + TO + 1 : 3 + TO;
        s_valid = 1'b1; s_data = DW'($urandom); filt_sel = 2'b01; dc_en = 1'b0;
        @(posedge clk);
        cur_sel = 2'b01; cur_dc = 1'b0;
        for (int s = 1; s <= end_s + 3; s++) begin
            @(negedge clk);
            e_busy = (s < end_s);
            e_st   = in_run && (s > dd) && (s <= dd + SC);
            if (s == end_s) exp_to = 1'b1;
            checks++; if (busy !== e_busy)        begin failures++; $display("FAIL to_busy run=%0d s=%0d got=%b req=%b", in_run, s, busy, e_busy); end
            checks++; if (timeout_err !== exp_to) begin failures++; $display("FAIL to_flag run=%0d s=%0d got=%b req=%b", in_run, s, timeout_err, exp_to); end
            checks++; if (m_valid !== 1'b0)       begin failures++; $display("FAIL to_m_valid run=%0d s=%0d got=%b req=0", in_run, s, m_valid); end
            checks++; if (sample_cnt !== exp_cnt) begin failures++; $display("FAIL to_cnt run=%0d s=%0d got=%0d req=%0d", in_run, s, sample_cnt, exp_cnt); end
            checks++; if (filt_start !== e_st)    begin failures++; $display("FAIL to_start run=%0d s=%0d got=%b req=%b", in_run, s, filt_start, e_st); end
            s_valid   = 1'b0;
            rbuf_done = in_run && (s == dd);
            filt_done = 1'b0;
            m_ready   = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b0;
    endtask

    task automatic test_timeout();
        pulse_reset();
        do_timeout(1'b0);
        pulse_reset();
        do_timeout(1'b1);
    endtask

    task automatic do_reset_mid(input int stop_s);
        int   dd;
        logic e_en, e_st;
        dd = 4;
        s_valid = 1'b1; s_data = 16'h5A5A; filt_sel = 2'b10; dc_en = 1'b1;
        @(posedge clk);
        for (int s = 1; s <= stop_s; s++) begin
            @(negedge clk);
            s_valid   = 1'b0;
            rbuf_done = (s == dd);
        end
        e_en = (stop_s <= 2);
        e_st = (stop_s > dd) && (stop_s <= dd + SC);
        checks++; if (rbuf_en !== e_en || filt_start !== e_st) begin
            failures++; $display("FAIL pre_rst_strobes stop=%0d rbuf_en=%b filt_start=%b req %b/%b",
                                 stop_s, rbuf_en, filt_start, e_en, e_st);
        end
        #1 rst = 1'b1;
        #1;
        checks++; if (rbuf_en !== 1'b0 || filt_start !== 1'b0) begin
            failures++; $display("FAIL async_rst_strobes stop=%0d rbuf_en=%b filt_start=%b req 0/0", stop_s, rbuf_en, filt_start);
        end
        checks++; if (busy !== 1'b0 || s_ready !== 1'b1) begin
            failures++; $display("FAIL async_rst_idle stop=%0d busy=%b s_ready=%b req 0/1", stop_s, busy, s_ready);
        end
        checks++; if (sample_cnt !== '0 || timeout_err !== 1'b0 || filt_dc_en !== 1'b0) begin
            failures++; $display("FAIL async_rst_regs stop=%0d cnt=%0d to=%b dc=%b req 0/0/0", stop_s, sample_cnt, timeout_err, filt_dc_en);
        end
        exp_cnt = '0; exp_to = 1'b0; cur_sel = '0; cur_dc = 1'b0; exp_mdata = '0;
        @(negedge clk);
        rst = 1'b0; rbuf_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rbuf_done   = 1'($urandom_range(0, 1));
            filt_done   = 1'($urandom_range(0, 1));
            filt_result = DW'($urandom);
            m_ready     = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || m_data !== exp_mdata) begin
                failures++; $display("FAIL post_rst_spurious i=%0d m_valid=%b busy=%b m_data=%h req 0/0/%h",
                                     i, m_valid, busy, m_data, exp_mdata);
            end
        end
        rbuf_done = 0; filt_done = 0; m_ready = 0;
    endtask

    task automatic test_reset_midrun();
        do_reset_mid(1);
        do_reset_mid(4 + 1);
        do_sample(16'h2468, 2'b10, 1'b1, 6, 20, 16'h1357, 2, 1'b1);
        checks++; if (sample_cnt !== 16'd1) begin
            failures++; $display("FAIL restart_cnt got=%0d req=1", sample_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_backpressure();
        test_addr_mux();
        test_random();
        test_timeout_boundary();
        test_timeout();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
